// File: rtl/cpu_memory_if.sv
// Data-bus bundle between the memory stage (master) and data memory (slave).
interface cpu_memory_if;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned MASK_W = XLEN / 8;

  logic              o_bus_request;
  logic              o_bus_rw;
  logic [XLEN-1:0]   o_bus_address;
  logic [XLEN-1:0]   o_bus_wdata;
  logic [MASK_W-1:0] o_bus_wmask;
  logic [XLEN-1:0]   i_bus_rdata;
  logic              i_bus_ready;

  modport master (
    output o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata, o_bus_wmask,
    input  i_bus_rdata, i_bus_ready
  );

  modport slave (
    input  o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata, o_bus_wmask,
    output i_bus_rdata, i_bus_ready
  );
endinterface

// File: rtl/cpu_memory.sv
// Rv32H memory-access stage: one data-bus transaction per load/store with lane steering and load extension.
// Define CPU_MEMORY_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of force-aligning them.
module cpu_memory (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_execute,
  input  logic         i_mem_read,
  input  logic         i_mem_write,
  input  logic [1:0]   i_mem_width,
  input  logic         i_mem_signed,
  input  logic [31:0]  i_address,
  input  logic [31:0]  i_store_data,
  input  logic [4:0]   i_inst_rd,
  input  logic [31:0]  i_rd,
  input  logic         i_branch,
  input  logic [31:0]  i_pc_next,
  cpu_memory_if.master bus,
  output logic [4:0]   o_inst_rd,
  output logic [31:0]  o_rd,
  output logic         o_branch,
  output logic [31:0]  o_pc_next,
  output logic         o_ready,
  output logic         o_busy,
  output logic         o_fault
);
  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned MASK_W = XLEN / 8;

  typedef enum logic [1:0] { IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2 } state_t;

  state_t state, state_nxt;

  // Instruction context held for the duration of the bus transaction
  logic [REG_W-1:0] ctx_inst_rd, ctx_inst_rd_nxt;
  logic [XLEN-1:0]  ctx_rd, ctx_rd_nxt;
  logic             ctx_branch, ctx_branch_nxt;
  logic [XLEN-1:0]  ctx_pc, ctx_pc_nxt;
  logic             ctx_load, ctx_load_nxt;
  logic [1:0]       ctx_width, ctx_width_nxt;
  logic             ctx_signed, ctx_signed_nxt;
  logic [1:0]       ctx_lane, ctx_lane_nxt;
  logic             ctx_fault, ctx_fault_nxt;

  logic              req_nxt, rw_nxt;
  logic [XLEN-1:0]   addr_nxt, wdata_nxt;
  logic [MASK_W-1:0] wmask_nxt;
  logic [REG_W-1:0]  inst_rd_nxt;
  logic [XLEN-1:0]   rd_nxt, pc_nxt;
  logic              branch_nxt, ready_nxt, busy_nxt, fault_nxt;

  logic              is_byte, is_half;
  logic [1:0]        lane;
  logic [XLEN-1:0]   lane_wdata;
  logic [MASK_W-1:0] lane_mask;
  logic [XLEN-1:0]   load_shift, load_data;

  // Lane steering of the incoming access; half/word lanes are force-aligned
  always_comb begin
    is_byte = (i_mem_width == 2'b00);
    is_half = (i_mem_width == 2'b01);
    if (is_byte) begin
      lane       = i_address[1:0];
      lane_wdata = {4{i_store_data[7:0]}};
      lane_mask  = MASK_W'(4'b0001) << lane;
    end else if (is_half) begin
      lane       = {i_address[1], 1'b0};
      lane_wdata = {2{i_store_data[15:0]}};
      lane_mask  = MASK_W'(4'b0011) << lane;
    end else begin
      lane       = 2'b00;
      lane_wdata = i_store_data;
      lane_mask  = MASK_W'(4'b1111);
    end
  end

`ifdef CPU_MEMORY_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = is_half ? i_address[0] : (!is_byte && (i_address[1:0] != 2'b00));
`endif

  // Load data: move the addressed lane to bit 0, then extend
  always_comb begin
    load_shift = bus.i_bus_rdata >> {ctx_lane, 3'b000};
    unique case (ctx_width)
      2'b00:   load_data = ctx_signed ? {{24{load_shift[7]}}, load_shift[7:0]}
                                      : {24'd0, load_shift[7:0]};
      2'b01:   load_data = ctx_signed ? {{16{load_shift[15]}}, load_shift[15:0]}
                                      : {16'd0, load_shift[15:0]};
      default: load_data = load_shift;
    endcase
  end

  always_comb begin
    state_nxt       = state;
    ctx_inst_rd_nxt = ctx_inst_rd;
    ctx_rd_nxt      = ctx_rd;
    ctx_branch_nxt  = ctx_branch;
    ctx_pc_nxt      = ctx_pc;
    ctx_load_nxt    = ctx_load;
    ctx_width_nxt   = ctx_width;
    ctx_signed_nxt  = ctx_signed;
    ctx_lane_nxt    = ctx_lane;
    ctx_fault_nxt   = ctx_fault;
    req_nxt         = bus.o_bus_request;
    rw_nxt          = bus.o_bus_rw;
    addr_nxt        = bus.o_bus_address;
    wdata_nxt       = bus.o_bus_wdata;
    wmask_nxt       = bus.o_bus_wmask;
    inst_rd_nxt     = '0;
    rd_nxt          = '0;
    branch_nxt      = 1'b0;
    pc_nxt          = '0;
    ready_nxt       = 1'b0;
    busy_nxt        = 1'b0;
    fault_nxt       = 1'b0;

    unique case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (i_execute) begin
          if (i_mem_read || i_mem_write) begin
            state_nxt       = ACCESS;
            busy_nxt        = 1'b1;
            ctx_inst_rd_nxt = i_inst_rd;
            ctx_branch_nxt  = i_branch;
            ctx_pc_nxt      = i_pc_next;
            ctx_load_nxt    = i_mem_read;
            ctx_width_nxt   = i_mem_width;
            ctx_signed_nxt  = i_mem_signed;
            ctx_lane_nxt    = lane;
`ifdef CPU_MEMORY_MISALIGN_TRAP_EN
            ctx_fault_nxt   = misaligned;
            ctx_rd_nxt      = misaligned ? i_address : i_rd;
`else
            ctx_fault_nxt   = 1'b0;
            ctx_rd_nxt      = i_rd;
`endif
            if (!ctx_fault_nxt) begin
              req_nxt   = 1'b1;
              rw_nxt    = i_mem_write;
              addr_nxt  = {i_address[31:2], 2'b00};
              wdata_nxt = i_mem_write ? lane_wdata : '0;
              wmask_nxt = i_mem_write ? lane_mask : '0;
            end
          end else begin
            ready_nxt   = 1'b1;
            inst_rd_nxt = i_inst_rd;
            rd_nxt      = i_rd;
            branch_nxt  = i_branch;
            pc_nxt      = i_pc_next;
          end
        end
      end
      ACCESS: begin
        busy_nxt = 1'b1;
        // A faulted access never raised a request, so it completes without the bus
        if (ctx_fault || bus.i_bus_ready) begin
          state_nxt   = DONE;
          busy_nxt    = 1'b0;
          ready_nxt   = 1'b1;
          inst_rd_nxt = ctx_inst_rd;
          branch_nxt  = ctx_branch;
          pc_nxt      = ctx_pc;
          fault_nxt   = ctx_fault;
          rd_nxt      = (ctx_load && !ctx_fault) ? load_data : ctx_rd;
          req_nxt     = 1'b0;
          rw_nxt      = 1'b0;
          addr_nxt    = '0;
          wdata_nxt   = '0;
          wmask_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state             <= IDLE;
      ctx_inst_rd       <= '0;
      ctx_rd            <= '0;
      ctx_branch        <= 1'b0;
      ctx_pc            <= '0;
      ctx_load          <= 1'b0;
      ctx_width         <= '0;
      ctx_signed        <= 1'b0;
      ctx_lane          <= '0;
      ctx_fault         <= 1'b0;
      bus.o_bus_request <= 1'b0;
      bus.o_bus_rw      <= 1'b0;
      bus.o_bus_address <= '0;
      bus.o_bus_wdata   <= '0;
      bus.o_bus_wmask   <= '0;
      o_inst_rd         <= '0;
      o_rd              <= '0;
      o_branch          <= 1'b0;
      o_pc_next         <= '0;
      o_ready           <= 1'b0;
      o_busy            <= 1'b0;
      o_fault           <= 1'b0;
    end else begin
      state             <= state_nxt;
      ctx_inst_rd       <= ctx_inst_rd_nxt;
      ctx_rd            <= ctx_rd_nxt;
      ctx_branch        <= ctx_branch_nxt;
      ctx_pc            <= ctx_pc_nxt;
      ctx_load          <= ctx_load_nxt;
      ctx_width         <= ctx_width_nxt;
      ctx_signed        <= ctx_signed_nxt;
      ctx_lane          <= ctx_lane_nxt;
      ctx_fault         <= ctx_fault_nxt;
      bus.o_bus_request <= req_nxt;
      bus.o_bus_rw      <= rw_nxt;
      bus.o_bus_address <= addr_nxt;
      bus.o_bus_wdata   <= wdata_nxt;
      bus.o_bus_wmask   <= wmask_nxt;
      o_inst_rd         <= inst_rd_nxt;
      o_rd              <= rd_nxt;
      o_branch          <= branch_nxt;
      o_pc_next         <= pc_nxt;
      o_ready           <= ready_nxt;
      o_busy            <= busy_nxt;
      o_fault           <= fault_nxt;
    end
  end
endmodule

// File: tb/tb_cpu_memory.sv
// Scoreboard bench for cpu_memory: byte-addressed reference memory, bus responder and result monitor.
module tb_cpu_memory;
  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_execute, i_mem_read, i_mem_write, i_mem_signed, i_branch;
  logic [1:0]  i_mem_width;
  logic [31:0] i_address, i_store_data, i_rd, i_pc_next;
  logic [4:0]  i_inst_rd;
  logic [4:0]  o_inst_rd;
  logic [31:0] o_rd, o_pc_next;
  logic        o_branch, o_ready, o_busy, o_fault;

  cpu_memory_if bus ();

  cpu_memory dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_execute(i_execute),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_width(i_mem_width),
    .i_mem_signed(i_mem_signed), .i_address(i_address), .i_store_data(i_store_data),
    .i_inst_rd(i_inst_rd), .i_rd(i_rd), .i_branch(i_branch), .i_pc_next(i_pc_next),
    .bus(bus),
    .o_inst_rd(o_inst_rd), .o_rd(o_rd), .o_branch(o_branch), .o_pc_next(o_pc_next),
    .o_ready(o_ready), .o_busy(o_busy), .o_fault(o_fault)
  );

  always #5 i_clock = ~i_clock;

  int cyc = 0;
  always @(posedge i_clock) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    logic [4:0]  inst_rd;
    logic [31:0] rd;
    logic        branch;
    logic [31:0] pc;
    logic        fault;
    int          kind;   // 0 ALU, 1 bus access, 2 trapped access
    int          cyc;
  } res_t;

  typedef struct {
    logic [31:0] addr;
    logic        rw;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } bus_t;

  res_t res_q[$];
  bus_t bus_q[$];
  int   done_q[$];
  int   force_wait = -1;

  // Reference memory: byte addressed, lazily filled from a fixed pattern
  logic [7:0]  shadow [int];
  logic [31:0] rmem   [int];

  function automatic logic [31:0] init_word(input int w);
    return 32'(w) * 32'h9E37_79B9 + 32'h0123_4567;
  endfunction

  function automatic logic [7:0] model_byte(input int a);
    logic [31:0] w;
    if (shadow.exists(a)) return shadow[a];
    w = init_word(a / 4);
    return w[8*(a%4) +: 8];
  endfunction

  task automatic issue(input logic rd_en, input logic wr_en, input logic [1:0] width,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [4:0] ird, input logic [31:0] alu, input logic br,
                       input logic [31:0] pcn, input int fw);
    res_t r;
    bus_t b;
    int size, eff, guard;
    logic [31:0] val;
    guard = 0;
    while (o_busy === 1'b1 && guard < 100) begin
      @(posedge i_clock); #1;
      guard++;
    end
    if (guard >= 100) check32("busy_timeout", 32'(o_busy), 32'd0);
    size = (width == 2'b00) ? 1 : (width == 2'b01) ? 2 : 4;
    eff  = int'(addr) - (int'(addr[1:0]) % size);
    val  = '0;
    r.inst_rd = ird; r.rd = alu; r.branch = br; r.pc = pcn; r.fault = 1'b0; r.kind = 0;
    b.addr = '0; b.rw = 1'b0; b.mask = '0; b.wdata = '0;
    if (rd_en || wr_en) begin
      r.kind = 1;
`ifdef CPU_MEMORY_MISALIGN_TRAP_EN
      if (eff != int'(addr)) begin
        r.kind = 2; r.fault = 1'b1; r.rd = addr;
      end
`endif
      if (r.kind == 1) begin
        b.addr = 32'(eff) & ~32'd3;
        b.rw   = wr_en;
        for (int j = 0; j < size; j++) begin
          int a;
          a = eff + j;
          if (wr_en) begin
            b.mask[a%4] = 1'b1;
            b.wdata[8*(a%4) +: 8] = sdata[8*j +: 8];
            shadow[a] = sdata[8*j +: 8];
          end else begin
            val[8*j +: 8] = model_byte(a);
          end
        end
        if (rd_en) begin
          if (size == 4)      r.rd = val;
          else if (size == 2) r.rd = sgn ? {{16{val[15]}}, val[15:0]} : {16'd0, val[15:0]};
          else                r.rd = sgn ? {{24{val[7]}}, val[7:0]} : {24'd0, val[7:0]};
        end
      end
    end
    force_wait   = fw;
    i_execute    = 1'b1; i_mem_read = rd_en; i_mem_write = wr_en; i_mem_width = width;
    i_mem_signed = sgn; i_address = addr; i_store_data = sdata; i_inst_rd = ird;
    i_rd = alu; i_branch = br; i_pc_next = pcn;
    @(posedge i_clock); #1;
    r.cyc = cyc;
    res_q.push_back(r);
    if (r.kind == 1) bus_q.push_back(b);
    // Scramble idle inputs: the stage must only sample them with i_execute
    i_execute = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
    i_mem_width = 2'($urandom); i_mem_signed = 1'($urandom); i_address = $urandom;
    i_store_data = $urandom; i_inst_rd = 5'($urandom); i_rd = $urandom;
    i_branch = 1'($urandom); i_pc_next = $urandom;
  endtask

  task automatic check_all_zero(input string tag);
    check32({tag, "_bus_request"}, 32'(bus.o_bus_request), 32'd0);
    check32({tag, "_bus_rw"},      32'(bus.o_bus_rw), 32'd0);
    check32({tag, "_bus_address"}, bus.o_bus_address, 32'd0);
    check32({tag, "_bus_wdata"},   bus.o_bus_wdata, 32'd0);
    check32({tag, "_bus_wmask"},   32'(bus.o_bus_wmask), 32'd0);
    check32({tag, "_inst_rd"},     32'(o_inst_rd), 32'd0);
    check32({tag, "_rd"},          o_rd, 32'd0);
    check32({tag, "_branch"},      32'(o_branch), 32'd0);
    check32({tag, "_pc_next"},     o_pc_next, 32'd0);
    check32({tag, "_ready"},       32'(o_ready), 32'd0);
    check32({tag, "_busy"},        32'(o_busy), 32'd0);
    check32({tag, "_fault"},       32'(o_fault), 32'd0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((res_q.size() != 0 || o_busy === 1'b1) && guard < 200) begin
      @(posedge i_clock); #1;
      guard++;
    end
    check32("drain_results", 32'(res_q.size()), 32'd0);
  endtask

  // Result monitor
  initial begin
    res_t r;
    int   exp_cyc;
    forever begin
      @(negedge i_clock);
      if (i_reset !== 1'b0) continue;
      if (o_ready === 1'b1) begin
        if (res_q.size() == 0) begin
          check32("unexpected_ready", 32'(o_ready), 32'd0);
        end else begin
          r = res_q.pop_front();
          exp_cyc = r.cyc;
          if (r.kind == 2) exp_cyc = r.cyc + 1;
          if (r.kind == 1) begin
            if (done_q.size() == 0) check32("bus_completion_missing", 32'(done_q.size()), 32'd1);
            else exp_cyc = done_q.pop_front();
          end
          check32("ready_cycle", 32'(cyc), 32'(exp_cyc));
          check32("inst_rd", 32'(o_inst_rd), 32'(r.inst_rd));
          check32("rd", o_rd, r.rd);
          check32("branch", 32'(o_branch), 32'(r.branch));
          check32("pc_next", o_pc_next, r.pc);
          check32("fault", 32'(o_fault), 32'(r.fault));
        end
      end else begin
        check32("idle_branch_pc", o_pc_next | 32'(o_branch), 32'd0);
      end
    end
  end

  // Bus responder: word memory with byte enables, random wait states, spurious idle ready
  initial begin
    bus_t        b;
    int          w, wi;
    bit          aborted;
    logic [31:0] word;
    bus.i_bus_ready = 1'b0;
    bus.i_bus_rdata = '0;
    forever begin
      @(negedge i_clock);
      if (bus.o_bus_request !== 1'b1) begin
        bus.i_bus_ready = ($urandom_range(0, 5) == 0);
        bus.i_bus_rdata = $urandom;
      end else begin
        bus.i_bus_ready = 1'b0;
        if (bus_q.size() == 0) begin
          check32("unexpected_request", 32'(bus.o_bus_request), 32'd0);
          b.addr = bus.o_bus_address; b.rw = bus.o_bus_rw; b.mask = '0; b.wdata = '0;
        end else begin
          b = bus_q.pop_front();
        end
        check32("bus_address", bus.o_bus_address, b.addr);
        check32("bus_rw", 32'(bus.o_bus_rw), 32'(b.rw));
        if (b.rw) begin
          check32("bus_wmask", 32'(bus.o_bus_wmask), 32'(b.mask));
          check32("bus_wdata", bus.o_bus_wdata & {{8{b.mask[3]}}, {8{b.mask[2]}},
                  {8{b.mask[1]}}, {8{b.mask[0]}}}, b.wdata);
        end
        w = (force_wait >= 0) ? force_wait : $urandom_range(0, 3);
        force_wait = -1;
        aborted = 1'b0;
        for (int k = 0; k < w; k++) begin
          @(negedge i_clock);
          if (bus.o_bus_request !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          check32("bus_address_held", bus.o_bus_address, b.addr);
        end
        if (!aborted) begin
          wi   = int'(bus.o_bus_address >> 2);
          word = rmem.exists(wi) ? rmem[wi] : init_word(wi);
          if (bus.o_bus_rw) begin
            for (int i = 0; i < 4; i++)
              if (bus.o_bus_wmask[i]) word[8*i +: 8] = bus.o_bus_wdata[8*i +: 8];
            rmem[wi] = word;
            bus.i_bus_rdata = $urandom;
          end else begin
            bus.i_bus_rdata = word;
          end
          bus.i_bus_ready = 1'b1;
          @(posedge i_clock); #1;
          done_q.push_back(cyc);
          bus.i_bus_ready = 1'b0;
          bus.i_bus_rdata = '0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int op;
    i_reset = 1'b1; i_execute = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
    i_mem_width = 2'b00; i_mem_signed = 1'b0; i_address = '0; i_store_data = '0;
    i_inst_rd = '0; i_rd = '0; i_branch = 1'b0; i_pc_next = '0;
    repeat (3) @(posedge i_clock);
    #1;
    check_all_zero("reset");
    i_reset = 1'b0;

    // ALU pass-through, with and without a taken branch
    issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 5'd5, 32'h0000_1234, 1'b0, 32'h0000_0104, -1);
    issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 5'd9, 32'hCAFE_F00D, 1'b1, 32'h0000_0800, -1);
    // Word store, then signed and unsigned byte loads of its top byte
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h1000, 32'h80FF_FFFF, 5'd0, 32'h1000, 1'b0, 32'h108, -1);
    issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h1003, 32'h0, 5'd10, 32'h1003, 1'b0, 32'h10C, 3);
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h1003, 32'h0, 5'd11, 32'h1003, 1'b0, 32'h110, 0);
    // Half store to the upper lanes, then signed half read-back
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h2002, 32'hDEAD_BEEF, 5'd0, 32'h2002, 1'b0, 32'h114, 1);
    issue(1'b1, 1'b0, 2'b01, 1'b1, 32'h2002, 32'h0, 5'd12, 32'h2002, 1'b0, 32'h118, -1);
    // Misaligned word load and half store
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h3001, 32'h0, 5'd13, 32'h3001, 1'b0, 32'h11C, -1);
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h2003, 32'h1234_5678, 5'd0, 32'h2003, 1'b0, 32'h120, -1);
    // Width 11 is a word; load then an ALU op issued in the load's completion cycle
    issue(1'b1, 1'b0, 2'b11, 1'b1, 32'h1000, 32'h0, 5'd14, 32'h1000, 1'b1, 32'h124, 2);
    issue(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd15, 32'h5555_AAAA, 1'b0, 32'h128, -1);
    drain();

    // Reset in the second cycle of a pending load abandons it
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h1100, 32'h0, 5'd7, 32'h1100, 1'b0, 32'h200, 6);
    @(posedge i_clock); #1;
    i_reset = 1'b1;
    @(posedge i_clock); #1;
    check_all_zero("abort");
    i_reset = 1'b0;
    res_q.delete();
    issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 5'd3, 32'h0BAD_F00D, 1'b1, 32'h300, -1);
    drain();

    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 2);
      issue(op == 1, op == 2, 2'($urandom), 1'($urandom), 32'h1000 + 32'($urandom_range(0, 31)),
            $urandom, 5'($urandom), $urandom, 1'($urandom), $urandom, -1);
      repeat ($urandom_range(0, 2)) @(posedge i_clock);
      #1;
    end
    drain();
    check32("bus_queue_empty", 32'(bus_q.size()), 32'd0);
    check32("completion_queue_empty", 32'(done_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/cpu_memory.md
# cpu_memory

Memory-access stage of the Rv32H pipeline, between execute and writeback. Takes an execute-stage result; for loads and stores it runs one data-bus transaction with byte-lane steering, then extends the load data. It forwards the destination register, result, branch flag and next PC to writeback with a one-cycle `o_ready` pulse. Non-memory instructions pass through with one cycle of latency.

## Interface
Parameters: none.

Ports:
- i_clock  in  1  single clock; everything samples on rising edge
- i_reset  in  1  reset, synchronous, active-high
- i_execute  in  1  one-cycle pulse: execute result valid
- i_mem_read  in  1  instruction is a load
- i_mem_write  in  1  instruction is a store; never both with i_mem_read
- i_mem_width  in  2  00 byte, 01 half, 10 word, 11 treated as word
- i_mem_signed  in  1  loads: 1 sign-extend, 0 zero-extend
- i_address  in  32  effective address (ALU result for memory ops)
- i_store_data  in  32  rs2 value for stores
- i_inst_rd  in  5  destination register index
- i_rd  in  32  ALU result (non-load result)
- i_branch  in  1  branch taken
- i_pc_next  in  32  next PC
- o_bus_request  out  1  bus transaction active
- o_bus_rw  out  1  1 write, 0 read
- o_bus_address  out  32  word-aligned address ({addr[31:2],2'b00})
- o_bus_wdata  out  32  lane-replicated store data
- o_bus_wmask  out  4  byte enables
- i_bus_rdata  in  32  read data, valid when i_bus_ready=1
- i_bus_ready  in  1  transaction complete
- o_inst_rd  out  5  to writeback
- o_rd  out  32  result to writeback
- o_branch  out  1  to writeback
- o_pc_next  out  32  to writeback
- o_ready  out  1  one-cycle result-valid pulse
- o_busy  out  1  stage occupied; upstream must hold off i_execute
- o_fault  out  1  misaligned access, qualified by o_ready

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE, i_execute=1, no memory op: latch i_inst_rd, i_rd, i_branch, i_pc_next into outputs and set o_ready=1. Stay in IDLE.
- IDLE, i_execute=1, load or store: latch all inputs and go to ACCESS. Set o_bus_request=1, o_bus_rw=i_mem_write, and o_busy=1.
- ACCESS: hold bus outputs stable until i_bus_ready is sampled 1. On that edge: drop o_bus_request, capture the load result, go to DONE.
- DONE: o_ready=1 for exactly one cycle, o_busy=0. Return to IDLE. An i_execute in DONE is accepted as in IDLE.
- i_execute while in ACCESS: ignored. Upstream contract forbids it.
- Store lanes, with a = addr[1:0]:
  - byte: wdata={4{d[7:0]}}, mask=4'b0001<<a
  - half: wdata={2{d[15:0]}}, mask=4'b0011<<a
  - word: wdata=d, mask=4'b1111
- Load: shift rdata right by 8*a, then take 8/16/32 bits and extend per i_mem_signed to give o_rd. Word loads ignore i_mem_signed.
- Stores: o_rd=i_rd, and writeback still receives o_inst_rd (decoder supplies x0).
- o_branch and o_pc_next travel with their instruction and are valid only while o_ready=1. Outside o_ready they are 0.

## Timing
- Reset: state=IDLE. All outputs are 0: o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata, o_bus_wmask, o_inst_rd, o_rd, o_branch, o_pc_next, o_ready, o_busy, o_fault.
- Reset during ACCESS: o_bus_request=0 from the reset edge; the pending transaction is abandoned.
- Non-memory latency: i_execute at edge N gives o_ready high for cycle N+1.
- Memory latency: i_execute at N gives o_bus_request from N+1. With i_bus_ready sampled at edge M, o_ready is high for cycle M+1. Best case, ready at the first request cycle: o_ready at N+2.
- i_bus_ready while o_bus_request=0: ignored.
- o_ready never stays high for two consecutive cycles for the same instruction.

## Configuration
- CPU_MEMORY_MISALIGN_TRAP_EN defined: a half access with a[0]=1, or a word access with a!=0, issues no bus request. The stage goes straight to DONE with o_fault=1 and o_rd=i_address (bad address). o_ready timing matches a non-memory op plus one cycle (o_ready at N+2).
- Not defined: the address is force-aligned (half: a[0]=0; word: a=00) and the access proceeds normally. o_fault is tied 0.

## Test plan
- ALU pass-through: i_execute with rd=5, i_rd=0x1234, no memory op -> o_ready at N+1, o_inst_rd=5, o_rd=0x1234, then o_ready=0 at N+2.
- Signed byte load: addr=0x1003, rdata=0x80FFFFFF, ready after 3 wait cycles -> request held 3 cycles with address 0x1000; o_rd=0xFFFFFF80 (unsigned variant: 0x00000080).
- Half store: addr=0x2002, data=0xDEADBEEF -> o_bus_rw=1, wdata=0xBEEFBEEF, wmask=4'b1100, address 0x2000.
- Misaligned word load at 0x3001: with the macro -> no request, o_fault=1, o_rd=0x3001. Without it -> address 0x3000, o_fault=0.
- Reset asserted in the second ACCESS cycle -> request low after that edge, all outputs 0, and a following ALU op completes normally.
- Back-to-back: i_execute in the DONE cycle of a load -> both results delivered, o_ready pulses in separate cycles, and o_busy is low between them.
